// File: rtl/key_pkg.sv
// Shared definitions for the push-button debouncer: state encoding,
// default timing parameters and the blink-mode step helper.
package key_pkg;

    localparam int DEBOUNCE_CYC_DEF = 1_000_000;
    localparam int LONG_CYC_DEF     = 50_000_000;

    localparam logic [1:0] ST_IDLE_ENC       = 2'd0;
    localparam logic [1:0] ST_PRESS_FILT_ENC = 2'd1;
    localparam logic [1:0] ST_DOWN_ENC       = 2'd2;
    localparam logic [1:0] ST_REL_FILT_ENC   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE       = ST_IDLE_ENC,
        ST_PRESS_FILT = ST_PRESS_FILT_ENC,
        ST_DOWN       = ST_DOWN_ENC,
        ST_REL_FILT   = ST_REL_FILT_ENC
    } key_state_t;

    function automatic logic [1:0] next_mode(input logic [1:0] mode);
        return mode + 2'd1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; the reset value
// is chosen by the instantiator so the output idles at the inactive level.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule

// File: rtl/key_debounce.sv
// Push-button debouncer with press/release/long-press strobes and a
// 2-bit blink-mode selector stepped by short presses.
//
//   state         | meaning
//   --------------+--------------------------------------------------
//   ST_IDLE       | key released and accepted as released
//   ST_PRESS_FILT | key seen pressed, qualifying it for DEBOUNCE_CYC
//   ST_DOWN       | press accepted, hold counter running toward LONG_CYC
//   ST_REL_FILT   | key seen released, qualifying it; hold counter frozen
module key_debounce
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYC   = DEBOUNCE_CYC_DEF,
    parameter int LONG_CYC       = LONG_CYC_DEF,
    parameter int KEY_ACTIVE_LOW = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_in,
    output logic       key_level,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       long_pulse,
    output logic [1:0] mode
);

    localparam int FW = $clog2(DEBOUNCE_CYC);
    localparam int HW = $clog2(LONG_CYC);
    localparam logic [FW-1:0] FILT_LAST  = FW'(DEBOUNCE_CYC - 1);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(LONG_CYC - 1);
    localparam logic          IDLE_LEVEL = (KEY_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    logic w_key_sync;
    logic w_key_s;

    key_state_t    r_state;
    logic [FW-1:0] r_filt_cnt;
    logic [HW-1:0] r_hold_cnt;
    logic          r_long_done;
    logic          r_key_level;
    logic          r_press;
    logic          r_release;
    logic          r_long;
    logic [1:0]    r_mode;

    sync_2ff #(
        .RST_VAL (IDLE_LEVEL)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (key_in),
        .q   (w_key_sync)
    );

    assign w_key_s = (KEY_ACTIVE_LOW != 0) ? ~w_key_sync : w_key_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_filt_cnt  <= '0;
            r_hold_cnt  <= '0;
            r_long_done <= 1'b0;
            r_key_level <= 1'b0;
            r_press     <= 1'b0;
            r_release   <= 1'b0;
            r_long      <= 1'b0;
            r_mode      <= 2'd0;
        end else begin
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_long    <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_key_s) begin
                        r_state    <= ST_PRESS_FILT;
                        r_filt_cnt <= '0;
                    end
                end

                ST_PRESS_FILT: begin
                    if (!w_key_s) begin
                        r_state <= ST_IDLE;
                    end else if (r_filt_cnt == FILT_LAST) begin
                        r_state     <= ST_DOWN;
                        r_press     <= 1'b1;
                        r_key_level <= 1'b1;
                        r_hold_cnt  <= '0;
                        r_long_done <= 1'b0;
                    end else begin
                        r_filt_cnt <= r_filt_cnt + 1'b1;
                    end
                end

                ST_DOWN: begin
                    // Saturated hold counter fires the long strobe once per press.
                    if (r_hold_cnt != HOLD_LAST) begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end else if (!r_long_done) begin
                        r_long      <= 1'b1;
                        r_long_done <= 1'b1;
                        r_mode      <= 2'd0;
                    end
                    if (!w_key_s) begin
                        r_state    <= ST_REL_FILT;
                        r_filt_cnt <= '0;
                    end
                end

                ST_REL_FILT: begin
                    if (w_key_s) begin
                        r_state <= ST_DOWN;
                    end else if (r_filt_cnt == FILT_LAST) begin
                        r_state     <= ST_IDLE;
                        r_release   <= 1'b1;
                        r_key_level <= 1'b0;
                        if (!r_long_done) begin
                            r_mode <= next_mode(r_mode);
                        end
                    end else begin
                        r_filt_cnt <= r_filt_cnt + 1'b1;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign key_level     = r_key_level;
    assign press_pulse   = r_press;
    assign release_pulse = r_release;
    assign long_pulse    = r_long;
    assign mode          = r_mode;

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with DEBOUNCE_CYC=8, LONG_CYC=40,
// active-low key; strobe timing is recorded by a negedge monitor.
module tb_key_debounce;

    logic       clk = 1'b0;
    logic       rst;
    logic       key_in;
    logic       key_level;
    logic       press_pulse;
    logic       release_pulse;
    logic       long_pulse;
    logic [1:0] mode;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int n_press, n_rel, n_long, n_lvl, n_multi;
    int t_press, t_rel, t_long;
    int e, e2;
    int exp_mode [4] = '{1, 2, 3, 0};

    key_debounce #(
        .DEBOUNCE_CYC   (8),
        .LONG_CYC       (40),
        .KEY_ACTIVE_LOW (1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .key_in        (key_in),
        .key_level     (key_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_pulse    (long_pulse),
        .mode          (mode)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (press_pulse)   begin n_press++; t_press = cyc; end
        if (release_pulse) begin n_rel++;   t_rel   = cyc; end
        if (long_pulse)    begin n_long++;  t_long  = cyc; end
        if (key_level)     n_lvl++;
        if (int'(press_pulse) + int'(release_pulse) + int'(long_pulse) > 1) n_multi++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        n_press = 0; n_rel = 0; n_long = 0; n_lvl = 0;
        t_press = -1; t_rel = -1; t_long = -1;
    endtask

    task automatic short_press();
        key_in = 1'b0;
        step(15);
        key_in = 1'b1;
        step(15);
    endtask

    initial begin
        n_multi = 0;
        clear_mon();
        rst    = 1'b1;
        key_in = 1'b1;
        step(3);
        check("reset_outputs", 32'({key_level, press_pulse, release_pulse, long_pulse, mode}), 32'd0);
        rst = 1'b0;
        step(5);

        // Clean press/release: strobes land 10 edges after the first sampling edge.
        clear_mon();
        e = cyc;
        key_in = 1'b0;
        step(20);
        key_in = 1'b1;
        e2 = cyc;
        step(5);
        check("t1_level_during_relfilt", 32'(key_level), 32'd1);
        step(10);
        check("t1_press_count", n_press, 1);
        check("t1_press_time", t_press, e + 11);
        check("t1_release_count", n_rel, 1);
        check("t1_release_time", t_rel, e2 + 11);
        check("t1_level_after", 32'(key_level), 32'd0);
        check("t1_mode", 32'(mode), 32'd1);
        check("t1_no_long", n_long, 0);

        // Bounce: never stable for 8 samples.
        clear_mon();
        for (int i = 0; i < 10; i++) begin
            key_in = ~key_in;
            step(3);
        end
        key_in = 1'b1;
        step(15);
        check("t2_no_press", n_press, 0);
        check("t2_no_release", n_rel, 0);
        check("t2_level_never_high", n_lvl, 0);
        check("t2_mode_kept", 32'(mode), 32'd1);

        // Long press: long strobe 40 edges after press, mode cleared and kept.
        clear_mon();
        e = cyc;
        key_in = 1'b0;
        step(60);
        check("t3_level_held", 32'(key_level), 32'd1);
        key_in = 1'b1;
        e2 = cyc;
        step(15);
        check("t3_press_time", t_press, e + 11);
        check("t3_long_count", n_long, 1);
        check("t3_long_time", t_long, e + 51);
        check("t3_release_count", n_rel, 1);
        check("t3_release_time", t_rel, e2 + 11);
        check("t3_mode", 32'(mode), 32'd0);

        // Four short presses cycle the mode 1,2,3,0.
        for (int i = 0; i < 4; i++) begin
            short_press();
            check("t4_mode_seq", 32'(mode), 32'(exp_mode[i]));
        end
        short_press();
        check("t4_mode_extra", 32'(mode), 32'd1);

        // Release glitch of 4 cycles: hold counter pauses 4 edges, long slips by 4.
        clear_mon();
        e = cyc;
        key_in = 1'b0;
        step(16);
        key_in = 1'b1;
        step(4);
        check("t5_level_in_glitch", 32'(key_level), 32'd1);
        key_in = 1'b0;
        step(60);
        check("t5_press_count", n_press, 1);
        check("t5_no_release", n_rel, 0);
        check("t5_long_count", n_long, 1);
        check("t5_long_time", t_long, e + 11 + 44);
        check("t5_mode_after_long", 32'(mode), 32'd0);
        key_in = 1'b1;
        step(15);
        check("t5_release_count", n_rel, 1);
        check("t5_mode_after_release", 32'(mode), 32'd0);

        // Reset mid-qualification: abort silently, then requalify from scratch.
        short_press();
        check("t6_mode_before", 32'(mode), 32'd1);
        clear_mon();
        e = cyc;
        key_in = 1'b0;
        step(8);
        rst = 1'b1;
        #1;
        check("t6_async_reset", 32'({key_level, press_pulse, release_pulse, long_pulse, mode}), 32'd0);
        step(2);
        rst = 1'b0;
        e2 = cyc;
        step(14);
        check("t6_press_count", n_press, 1);
        check("t6_press_time", t_press, e2 + 11);
        check("t6_no_release", n_rel, 0);
        check("t6_level", 32'(key_level), 32'd1);
        key_in = 1'b1;
        step(15);
        check("t6_mode_after", 32'(mode), 32'd1);
        check("strobe_overlap", n_multi, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
